change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 12 +
 rtl/coin_stock.sv | 20 ++
 rtl/change_dispenser.sv | 93 +++++++++
 tb/tb_change_dispenser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: shared denomination encoding, coin values and payout state enum.
package vending_pkg;
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {D1 = 2'd0, D5 = 2'd1, D10 = 2'd2, D50 = 2'd3} denom_t;
  localparam logic [7:0] VAL_1  = 8'd1;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_50 = 8'd50;
  function automatic logic [7:0] denom_value(input denom_t d);
    return d == D50 ? VAL_50 : d == D10 ? VAL_10 : d == D5 ? VAL_5 : VAL_1;
  endfunction
endpackage

// File: rtl/coin_stock.sv
// coin_stock: 8-bit coin counter with saturating add and single-coin take in the same cycle.
module coin_stock #(
  parameter logic [7:0] INIT = 8'd20
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_add,
  input  logic [7:0] i_add_count,
  input  logic       i_take,
  output logic [7:0] o_count
);
  logic [7:0] r_count;
  logic [9:0] w_sum;
  assign w_sum = {2'b0, r_count} + (i_add ? {2'b0, i_add_count} : 10'd0) - {9'd0, i_take};
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (i_reset) r_count <= INIT;
    else         r_count <= w_sum > 10'd255 ? 8'hff : w_sum[7:0];
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout FSM with hopper handshake.
// Define CHANGE_STOCK_EN to track per-denomination stock and report shortfalls.
module change_dispenser
  import vending_pkg::*;
#(
  parameter logic [7:0] INIT_STOCK = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  output logic       busy,
  output logic       coin_valid,
  output logic [7:0] coin_value,
  input  logic       coin_ready,
  output logic       done,
  output logic       short,
  output logic [7:0] shortfall,
  input  logic       refill_valid,
  input  logic [1:0] refill_denom,
  input  logic [7:0] refill_count
);
  state_t     r_state, w_next;
  logic [7:0] r_remaining, r_coin_value, r_shortfall;
  logic       r_short;
  logic [3:0] w_avail, w_ok;
  logic       w_found, w_hs;
  denom_t     w_pick;
  assign w_hs = r_state == ISSUE && coin_ready;
`ifdef CHANGE_STOCK_EN
  logic [7:0] w_stock [4];
  for (genvar i = 0; i < 4; i++) begin : g_stock
    coin_stock #(.INIT(INIT_STOCK)) u_stock (
      .clk         (clk),
      .i_reset     (reset),
      .i_add       (refill_valid && refill_denom == 2'(i)),
      .i_add_count (refill_count),
      .i_take      (w_hs && r_coin_value == denom_value(denom_t'(i))),
      .o_count     (w_stock[i])
    );
    assign w_avail[i] = w_stock[i] != 8'd0;
  end
  assign short = r_short;
`else
  logic w_unused;
  assign w_unused = ^{refill_valid, refill_denom, refill_count, r_short};
  assign w_avail  = 4'hf;
  assign short    = 1'b0;
`endif
  for (genvar j = 0; j < 4; j++) begin : g_ok
    assign w_ok[j] = w_avail[j] && r_remaining >= denom_value(denom_t'(j));
  end
  assign w_found    = |w_ok;
  assign w_pick     = w_ok[3] ? D50 : w_ok[2] ? D10 : w_ok[1] ? D5 : D1;
  assign coin_value = r_coin_value;
  assign shortfall  = r_shortfall;
  always_comb begin
    w_next     = r_state;
    busy       = r_state != IDLE;
    coin_valid = r_state == ISSUE;
    done       = r_state == DONE;
    case (r_state)
      IDLE:    w_next = start ? SELECT : IDLE;
      SELECT:  w_next = (r_remaining != 8'd0 && w_found) ? ISSUE : DONE;
      ISSUE:   w_next = coin_ready ? SELECT : ISSUE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_remaining  <= 8'd0;
      r_coin_value <= 8'd0;
      r_short      <= 1'b0;
      r_shortfall  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_remaining <= amount;
        r_short     <= 1'b0;
        r_shortfall <= 8'd0;
      end
      if (r_state == SELECT && w_next == ISSUE) r_coin_value <= denom_value(w_pick);
      // SELECT falling to DONE with money left means nothing eligible remains
      if (r_state == SELECT && w_next == DONE && r_remaining != 8'd0) begin
        r_short     <= 1'b1;
        r_shortfall <= r_remaining;
      end
      if (w_hs) r_remaining <= r_remaining - r_coin_value;
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: greedy payout model checked every cycle plus directed literal scenarios.
module tb_change_dispenser;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, coin_ready = 1'b1, refill_valid = 1'b0;
  logic [7:0] amount = 8'd0, refill_count = 8'd0;
  logic [1:0] refill_denom = 2'd0;
  logic       busy, coin_valid, done, short;
  logic [7:0] coin_value, shortfall;
  int tests = 0, fails = 0;
  localparam int DV [4] = '{1, 5, 10, 50};
  int m_stock [4];
  int m_d [4];
  int m_rem, m_val, m_shortfall;
  bit m_active, m_offer, m_short;
  int got [$];
  int n;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .busy(busy),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
    .done(done), .short(short), .shortfall(shortfall), .refill_valid(refill_valid),
    .refill_denom(refill_denom), .refill_count(refill_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int rem);
    for (int i = 3; i >= 0; i--)
`ifdef CHANGE_STOCK_EN
      if (DV[i] <= rem && m_stock[i] > 0) return DV[i];
`else
      if (DV[i] <= rem) return DV[i];
`endif
    return 0;
  endfunction

  function automatic int idx_of(input int v);
    for (int i = 0; i < 4; i++) if (DV[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_stock[i] = 20;
    m_rem = 0; m_val = 0; m_active = 0; m_offer = 0; m_short = 0; m_shortfall = 0;
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    else begin
      chk("busy", busy, m_active);
      if (!m_active) begin
        chk("idle_coin_valid", coin_valid, 0);
        chk("idle_done", done, 0);
      end
      if (!done) begin
        chk("short_hold", short, m_short);
        chk("shortfall_hold", shortfall, m_shortfall);
      end
      if (coin_valid) begin
        if (!m_offer) chk("coin_pick", coin_value, pick(m_rem));
        else          chk("coin_stable", coin_value, m_val);
        m_offer = 1;
        m_val   = coin_value;
      end
      if (done) begin
        chk("short", short, int'(m_rem != 0));
        chk("shortfall", shortfall, m_rem);
        if (m_rem != 0) chk("short_but_coin_eligible", pick(m_rem), 0);
        m_short = m_rem != 0;
        m_shortfall = m_rem;
      end
      for (int i = 0; i < 4; i++) m_d[i] = 0;
`ifdef CHANGE_STOCK_EN
      if (refill_valid) m_d[refill_denom] += refill_count;
`endif
      if (coin_valid && coin_ready) begin
        got.push_back(coin_value);
        m_rem -= coin_value;
        m_offer = 0;
`ifdef CHANGE_STOCK_EN
        m_d[idx_of(coin_value)] -= 1;
`endif
      end
      for (int i = 0; i < 4; i++) m_stock[i] = (m_stock[i] + m_d[i] > 255) ? 255 : m_stock[i] + m_d[i];
      if (done) m_active = 0;
      else if (!m_active && start) begin
        m_active = 1; m_rem = amount; m_short = 0; m_shortfall = 0;
      end
    end
  end

  // Returns cycles from the start-sampling edge until done is seen.
  task automatic payout(input int amt, input int hold, output int cyc);
    int vc;
    vc = 0;
    @(posedge clk); #1;
    got.delete();
    start = 1; amount = 8'(amt); coin_ready = (hold == 0);
    @(posedge clk); #1;
    start = 0; cyc = 1;
    while (!done && cyc < 2000) begin
      if (coin_valid) begin
        vc++;
        if (vc > hold) coin_ready = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("payout_timeout", int'(cyc >= 2000), 0);
    coin_ready = 1;
  endtask

  task automatic chk_coins(input string name, input int exp [$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  task automatic refill(input int d, input int c);
    @(posedge clk); #1;
    refill_valid = 1; refill_denom = 2'(d); refill_count = 8'(c);
    @(posedge clk); #1;
    refill_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy, 0); chk("rst_valid", coin_valid, 0); chk("rst_value", coin_value, 0);
    chk("rst_done", done, 0); chk("rst_short", short, 0); chk("rst_shortfall", shortfall, 0);
    reset = 0;
    payout(87, 0, n);
    chk("p87_cycles", n, 16);
    chk_coins("p87", '{50, 10, 10, 10, 5, 1, 1});
    chk("p87_short", short, 0);
    payout(0, 0, n);
    chk("p0_cycles", n, 2);
    chk("p0_coins", got.size(), 0);
    chk("p0_short", short, 0);
    payout(10, 5, n);
    chk("hold_cycles", n, 9);
    chk_coins("hold", '{10});
    fork
      payout(87, 0, n);
      begin
        repeat (4) @(posedge clk); #1;
        refill_valid = 1; refill_denom = 2'd2; refill_count = 8'd7;
        repeat (5) @(posedge clk); #1;
        refill_valid = 0;
      end
    join
    chk_coins("p87_refill", '{50, 10, 10, 10, 5, 1, 1});
    @(posedge clk); #1;
    start = 1; amount = 8'd100; coin_ready = 0;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (!coin_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_mid_offer", coin_valid, 1);
    chk("rst_mid_value", coin_value, 50);
    repeat (2) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_mid_valid", coin_valid, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    coin_ready = 1;
    repeat (3) begin @(posedge clk); #1; chk("rst_mid_no_done", done, 0); end
`ifdef CHANGE_STOCK_EN
    for (int k = 0; k < 4; k++) begin
      payout(250, 0, n);
      chk_coins("drain50", '{50, 50, 50, 50, 50});
    end
    payout(60, 0, n);
    chk_coins("p60", '{10, 10, 10, 10, 10, 10});
    chk("p60_short", short, 0);
    payout(140, 0, n);
    chk("p140_count", got.size(), 14);
    payout(10, 0, n);
    chk_coins("p10_no10", '{5, 5});
    for (int k = 0; k < 5; k++) begin
      payout(9, 0, n);
      chk_coins("p9", '{5, 1, 1, 1, 1});
    end
    payout(65, 0, n);
    chk("p65_count", got.size(), 13);
    payout(3, 0, n);
    chk("p3_coins", got.size(), 0);
    chk("p3_short", short, 1);
    chk("p3_shortfall", shortfall, 3);
    refill(0, 2);
    payout(3, 0, n);
    chk_coins("p3_refill", '{1, 1});
    chk("p3r_short", short, 1);
    chk("p3r_shortfall", shortfall, 1);
`endif
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
